// File: rtl/game_state_fsm.sv
// game_state_fsm: top-level sequencer for two-player battleship.
// Walks idle -> ship placement (P1, P2) -> alternating firing turns -> game over,
// counting placed ships and hits per player and declaring the winner.
// Optional feature: define TURN_TIMEOUT_EN to pass a turn (as a miss) to the other
// player once TURN_TIMEOUT_CYCLES cycles go by without a shot.
module game_state_fsm #(
    parameter int SHIPS_PER_PLAYER    = 5,
    parameter int HITS_TO_WIN         = 17,
    parameter int TURN_TIMEOUT_CYCLES = 100000000
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic                                   place_done,
    input  logic                                   fire_valid,
    input  logic                                   fire_hit,
    output logic [2:0]                             state,
    output logic [1:0]                             winner,
    output logic [$clog2(HITS_TO_WIN+1)-1:0]       p1_hits,
    output logic [$clog2(HITS_TO_WIN+1)-1:0]       p2_hits,
    output logic [$clog2(SHIPS_PER_PLAYER+1)-1:0]  ships_placed,
    output logic                                   turn_pulse,
    output logic                                   timeout_pulse
);

    localparam int HW = $clog2(HITS_TO_WIN + 1);
    localparam int SW = $clog2(SHIPS_PER_PLAYER + 1);

    localparam logic [HW-1:0] HITS_LIM  = HW'(HITS_TO_WIN);
    localparam logic [SW-1:0] SHIPS_LIM = SW'(SHIPS_PER_PLAYER);

    // Elaboration-time guard: every limit must be at least one.
    if (SHIPS_PER_PLAYER < 1 || HITS_TO_WIN < 1 || TURN_TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("game_state_fsm: SHIPS_PER_PLAYER, HITS_TO_WIN and TURN_TIMEOUT_CYCLES must be >= 1");
    end

    // Encoding is visible on the state bus, so the values are fixed.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        P1_PLACE  = 3'd1,
        P2_PLACE  = 3'd2,
        P1_TURN   = 3'd3,
        P2_TURN   = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      winner_q, winner_d;
    logic [HW-1:0]   p1_q, p1_d;
    logic [HW-1:0]   p2_q, p2_d;
    logic [SW-1:0]   ships_q, ships_d;
    logic            turn_pulse_q;
    logic            timeout_q, timeout_d;
    logic            expired;

`ifdef TURN_TIMEOUT_EN
    localparam int TW = (TURN_TIMEOUT_CYCLES > 1) ? $clog2(TURN_TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TURN_TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          in_turn;

    assign in_turn = (state_q == P1_TURN) || (state_q == P2_TURN);
    assign expired = in_turn && (timer_q == TIMER_LAST);

    // Turn timer: restarts on every state change or shot, idles at 0 outside turns.
    always_comb begin
        timer_d = timer_q;
        if (!in_turn || fire_valid || (state_d != state_q)) begin
            timer_d = '0;
        end else if (timer_q != TIMER_LAST) begin
            timer_d = timer_q + TW'(1);
        end
    end

    // Turn timer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign expired = 1'b0;
`endif

    // Next-state and next-counter logic.
    // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        ships_d   = ships_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = P1_PLACE;
                    winner_d = 2'd0;
                    p1_d     = '0;
                    p2_d     = '0;
                    ships_d  = '0;
                end
            end

            P1_PLACE, P2_PLACE: begin
                if (place_done) begin
                    if (ships_q + SW'(1) == SHIPS_LIM) begin
                        ships_d = '0;
                        state_d = (state_q == P1_PLACE) ? P2_PLACE : P1_TURN;
                    end else if (ships_q < SHIPS_LIM) begin
                        ships_d = ships_q + SW'(1);
                    end
                end
            end

            P1_TURN: begin
                if (fire_valid) begin
                    if (fire_hit && (p1_q < HITS_LIM)) begin
                        p1_d = p1_q + HW'(1);
                    end
                    if (fire_hit && (p1_d == HITS_LIM)) begin
                        state_d  = GAME_OVER;
                        winner_d = 2'd1;
                    end else begin
                        state_d = P2_TURN;
                    end
                end else if (expired) begin
                    state_d   = P2_TURN;
                    timeout_d = 1'b1;
                end
            end

            P2_TURN: begin
                if (fire_valid) begin
                    if (fire_hit && (p2_q < HITS_LIM)) begin
                        p2_d = p2_q + HW'(1);
                    end
                    if (fire_hit && (p2_d == HITS_LIM)) begin
                        state_d  = GAME_OVER;
                        winner_d = 2'd2;
                    end else begin
                        state_d = P1_TURN;
                    end
                end else if (expired) begin
                    state_d   = P1_TURN;
                    timeout_d = 1'b1;
                end
            end

            GAME_OVER: begin
                if (start) begin
                    state_d = IDLE;
                end
            end

            // Codes 6 and 7 recover to IDLE on the next clock.
            default: state_d = IDLE;
        endcase
    end

    // State, counter and pulse registers; every output comes straight from here.
    // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            winner_q     <= 2'd0;
            p1_q         <= '0;
            p2_q         <= '0;
            ships_q      <= '0;
            turn_pulse_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            ships_q      <= ships_d;
            turn_pulse_q <= (state_d != state_q);
            timeout_q    <= timeout_d;
        end
    end

    assign state         = state_q;
    assign winner        = winner_q;
    assign p1_hits       = p1_q;
    assign p2_hits       = p2_q;
    assign ships_placed  = ships_q;
    assign turn_pulse    = turn_pulse_q;
    assign timeout_pulse = timeout_q;

endmodule
